// File: rtl/axi_fifo_rr_arb_if.sv
// Bus bundle for axi_fifo_rr_arb: NUM_PORTS AXI-Stream requesters in, one tagged stream out
// toward the FIFO write port, plus the FIFO's almost_full flag.
interface axi_fifo_rr_arb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PORTS  = 4,
   parameter int ID_WIDTH   = 2
);
   logic [NUM_PORTS-1:0]            s_axis_tvalid;
   logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
   logic [NUM_PORTS-1:0]            s_axis_tlast;
   logic [NUM_PORTS-1:0]            s_axis_tready;
   logic                            fifo_almost_full;
   logic                            m_axis_tvalid;
   logic [DATA_WIDTH-1:0]           m_axis_tdata;
   logic                            m_axis_tlast;
   logic [ID_WIDTH-1:0]             m_axis_tid;
   logic                            m_axis_tready;

   // Handshake: a beat transfers on a rising clk edge where tvalid & tready are both high;
   // a source holds tdata/tlast stable while tvalid is high and tready is low.
   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, fifo_almost_full, m_axis_tready,
      output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tlast, fifo_almost_full, m_axis_tready,
      input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
   );
endinterface

// File: rtl/axi_fifo_rr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_PORTS AXI-Stream requesters;
// a grant lasts one packet or BURST_LEN beats, and almost_full only gates new grants.
module axi_fifo_rr_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PORTS  = 4,
   parameter int ID_WIDTH   = 2,
   parameter int BURST_LEN  = 16
) (
   input  logic                clk,
   input  logic                sync_reset,
   axi_fifo_rr_arb_if.slave    bus,
   output logic                busy
);
   typedef enum logic {IDLE, XFER} state_t;

   localparam logic [7:0]          LAST_BEAT = 8'(BURST_LEN - 1);
   localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);

   state_t              state, state_nxt;
   logic [ID_WIDTH-1:0] grant, last_grant;
   logic [ID_WIDTH-1:0] sel, idx;
   logic                sel_found;
   logic [7:0]          beat_cnt;
   logic                beat_acc;

   // Search starts just after the previous winner, so the port that just finished is last.
   always_comb begin : rr_search
      sel       = '0;
      idx       = '0;
      sel_found = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = ID_WIDTH'((int'(last_grant) + i) % NUM_PORTS);
         if (!sel_found && bus.s_axis_tvalid[idx]) begin
            sel       = idx;
            sel_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin : state_reg
      if (sync_reset) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin : fsm_comb
      state_nxt         = state;
      busy              = 1'b0;
      beat_acc          = 1'b0;
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tdata  = '0;
      bus.m_axis_tlast  = 1'b0;
      bus.m_axis_tid    = '0;
      bus.s_axis_tready = '0;
      case (state)
         IDLE: begin
            if (!bus.fifo_almost_full && sel_found) state_nxt = XFER;
         end
         XFER: begin
            busy                     = 1'b1;
            bus.m_axis_tvalid        = bus.s_axis_tvalid[grant];
            bus.m_axis_tdata         = bus.s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            bus.m_axis_tid           = grant;
            // Burst truncation ends the grant with tlast even mid-packet.
            bus.m_axis_tlast         = bus.s_axis_tlast[grant] | (beat_cnt == LAST_BEAT);
            bus.s_axis_tready[grant] = bus.m_axis_tready;
            beat_acc                 = bus.m_axis_tvalid & bus.m_axis_tready;
            if (beat_acc && bus.m_axis_tlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : grant_regs
      if (sync_reset) begin
         grant      <= '0;
         last_grant <= LAST_PORT;
         beat_cnt   <= '0;
      end else begin
         if (state == IDLE && state_nxt == XFER) begin
            grant    <= sel;
            beat_cnt <= '0;
         end
         if (beat_acc) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (bus.m_axis_tlast) last_grant <= grant;
         end
      end
   end
endmodule

// File: tb/tb_axi_fifo_rr_arb.sv
// Bench for axi_fifo_rr_arb: per-cycle vector table for arbitration timing, then
// source-model sequences whose output beats are checked against an expected queue.
module tb_axi_fifo_rr_arb;
   localparam int DW = 32;
   localparam int NP = 4;
   localparam int IW = 2;
   localparam int BL = 4;
   localparam int EW = NP + IW + 3;
   localparam int W  = 16 + IW + 1 + DW;

   logic clk = 1'b0;
   logic sync_reset;
   logic busy;

   always #5 clk = ~clk;

   axi_fifo_rr_arb_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .ID_WIDTH(IW)) bus ();

   axi_fifo_rr_arb #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .ID_WIDTH(IW), .BURST_LEN(BL)) dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .bus        (bus.slave),
      .busy       (busy)
   );

   typedef struct {
      logic          rst;
      logic [NP-1:0] tv;
      logic [NP-1:0] tl;
      logic          af;
      logic          mr;
      logic [EW-1:0] exp;
   } vec_t;

   vec_t        vecs [21];
   logic [W-1:0] exp_q [$];
   logic [DW:0]  src_q [NP][$];
   logic [NP-1:0] fire, nxt_hold;
   logic         nxt_af, nxt_mr;
   int           cyc;
   int           n_vec = 0;
   int           n_err = 0;

   function automatic vec_t mk(input logic rst, input logic [NP-1:0] tv, input logic [NP-1:0] tl,
                               input logic af, input logic mr, input logic mv,
                               input logic [IW-1:0] tid, input logic ml,
                               input logic [NP-1:0] sr, input logic bz);
      vec_t v;
      v.rst = rst; v.tv = tv; v.tl = tl; v.af = af; v.mr = mr;
      v.exp = {mv, tid, ml, sr, bz};
      return v;
   endfunction

   function automatic logic [DW-1:0] dat(input int p, input int pkt, input int b);
      return {8'(p), 8'(pkt), 16'(b)};
   endfunction

   task automatic push_exp(input int c, input int tid, input logic last, input logic [DW-1:0] d);
      exp_q.push_back({(c < 0) ? 16'hFFFF : 16'(c), IW'(tid), last, d});
   endtask

   task automatic add_pkt(input int p, input int pkt, input int len);
      for (int b = 0; b < len; b++) src_q[p].push_back({(b == len - 1), dat(p, pkt, b)});
   endtask

   task automatic clear_inputs();
      bus.s_axis_tvalid    = '0;
      bus.s_axis_tdata     = '0;
      bus.s_axis_tlast     = '0;
      bus.fifo_almost_full = 1'b0;
      bus.m_axis_tready    = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      sync_reset = 1'b1;
      clear_inputs();
      nxt_af = 1'b0; nxt_mr = 1'b1; nxt_hold = '0; fire = '0;
      for (int p = 0; p < NP; p++) src_q[p].delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 sync_reset = 1'b0;
      cyc = 0;
   endtask

   task automatic apply_vec(input vec_t v, input int n);
      logic [EW-1:0] got;
      @(posedge clk); #1;
      sync_reset           = v.rst;
      bus.s_axis_tvalid    = v.tv;
      bus.s_axis_tlast     = v.tl;
      bus.fifo_almost_full = v.af;
      bus.m_axis_tready    = v.mr;
      @(negedge clk);
      got = {bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tlast, bus.s_axis_tready, busy};
      n_vec++;
      if (got !== v.exp) begin
         n_err++;
         $display("FAIL vec%0d {tvalid,tid,tlast,tready,busy}: got %b expected %b", n, got, v.exp);
      end
   endtask

   // One cycle of the source model: retire beats taken at the last edge, drive, then monitor.
   task automatic step();
      logic [W-1:0] got, e;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++)
         if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      bus.fifo_almost_full = nxt_af;
      bus.m_axis_tready    = nxt_mr;
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() > 0 && !nxt_hold[p]) begin
            bus.s_axis_tvalid[p]          = 1'b1;
            bus.s_axis_tdata[p*DW +: DW]  = src_q[p][0][DW-1:0];
            bus.s_axis_tlast[p]           = src_q[p][0][DW];
         end else begin
            bus.s_axis_tvalid[p]          = 1'b0;
            bus.s_axis_tdata[p*DW +: DW]  = '0;
            bus.s_axis_tlast[p]           = 1'b0;
         end
      end
      @(negedge clk);
      fire = bus.s_axis_tvalid & bus.s_axis_tready;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
         n_vec++;
         got = {16'(cyc), bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata};
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL beat unexpected: got %h at cycle %0d, expected none", got, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e[W-1 -: 16] == 16'hFFFF) got[W-1 -: 16] = 16'hFFFF;
            if (got !== e) begin
               n_err++;
               $display("FAIL beat {cyc,tid,last,data}: got %h expected %h", got, e);
            end
         end
      end
      cyc++;
   endtask

   task automatic set_ctrl(input int mode);
      case (mode)
         2: nxt_hold = (cyc == 3 || cyc == 4) ? 4'b0010 : 4'b0000;
         3: nxt_af   = (cyc < 10);
         4: begin
            nxt_af = (cyc >= 2 && cyc < 16);
            nxt_mr = (cyc >= 2 && cyc < 16) ? ~cyc[0] : 1'b1;
         end
         default: ;
      endcase
   endtask

   task automatic drain(input int mode, input int budget, input string name);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < budget) begin
         set_ctrl(mode);
         step();
         if (mode == 3 && cyc <= 10) begin
            n_vec++;
            if (bus.m_axis_tvalid !== 1'b0) begin
               n_err++;
               $display("FAIL %s almost_full gate: m_axis_tvalid got %b expected 0", name, bus.m_axis_tvalid);
            end
         end
         k++;
      end
      if (exp_q.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s timeout: %0d beats outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      sync_reset = 1'b1;
      clear_inputs();
      nxt_af = 1'b0; nxt_mr = 1'b1; nxt_hold = '0; fire = '0; cyc = 0;
      repeat (3) @(posedge clk);

      vecs[0]  = mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0);
      vecs[1]  = mk(0, 4'b0101, 4'b0000, 1, 1, 0, 0, 0, 4'b0000, 0);
      vecs[2]  = mk(0, 4'b0101, 4'b0000, 1, 1, 0, 0, 0, 4'b0000, 0);
      vecs[3]  = mk(0, 4'b0101, 4'b0000, 1, 1, 0, 0, 0, 4'b0000, 0);
      vecs[4]  = mk(0, 4'b0101, 4'b0001, 0, 1, 0, 0, 0, 4'b0000, 0);
      vecs[5]  = mk(0, 4'b0101, 4'b0001, 0, 1, 1, 0, 1, 4'b0001, 1);
      vecs[6]  = mk(0, 4'b0101, 4'b0101, 0, 1, 0, 0, 0, 4'b0000, 0);
      vecs[7]  = mk(0, 4'b0101, 4'b0101, 0, 1, 1, 2, 1, 4'b0100, 1);
      vecs[8]  = mk(0, 4'b1000, 4'b1000, 0, 1, 0, 0, 0, 4'b0000, 0);
      vecs[9]  = mk(0, 4'b1000, 4'b1000, 0, 1, 1, 3, 1, 4'b1000, 1);
      vecs[10] = mk(0, 4'b1000, 4'b1000, 0, 1, 0, 0, 0, 4'b0000, 0);
      vecs[11] = mk(0, 4'b1000, 4'b1000, 0, 1, 1, 3, 1, 4'b1000, 1);
      vecs[12] = mk(0, 4'b1000, 4'b1000, 0, 1, 0, 0, 0, 4'b0000, 0);
      vecs[13] = mk(0, 4'b1000, 4'b1000, 0, 0, 1, 3, 1, 4'b0000, 1);
      vecs[14] = mk(0, 4'b1000, 4'b1000, 0, 1, 1, 3, 1, 4'b1000, 1);
      vecs[15] = mk(0, 4'b1000, 4'b1000, 0, 1, 0, 0, 0, 4'b0000, 0);
      vecs[16] = mk(0, 4'b1000, 4'b0000, 0, 1, 1, 3, 0, 4'b1000, 1);
      vecs[17] = mk(1, 4'b1001, 4'b0000, 0, 1, 1, 3, 0, 4'b1000, 1);
      vecs[18] = mk(0, 4'b1001, 4'b1001, 0, 1, 0, 0, 0, 4'b0000, 0);
      vecs[19] = mk(0, 4'b1001, 4'b1001, 0, 1, 1, 0, 1, 4'b0001, 1);
      vecs[20] = mk(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 0);

      for (int p = 0; p < NP; p++) bus.s_axis_tdata[p*DW +: DW] = 32'hC0DE_0000 + 32'(p);
      for (int i = 0; i < 21; i++) apply_vec(vecs[i], i);

      // Four 3-beat packets: strict 0..3 order, first beat one cycle after request, one bubble.
      do_reset();
      for (int p = 0; p < NP; p++) add_pkt(p, 0, 3);
      for (int i = 0; i < 12; i++) push_exp(1 + i + i / 3, i / 3, (i % 3) == 2, dat(i / 3, 0, i % 3));
      drain(1, 40, "rr_order");

      // 10-beat packet on port 1 truncated to bursts of 4, interleaved with port 2.
      do_reset();
      add_pkt(1, 0, 10);
      add_pkt(2, 0, 3);
      for (int b = 0; b < 4; b++) push_exp(-1, 1, b == 3, dat(1, 0, b));
      for (int b = 0; b < 3; b++) push_exp(-1, 2, b == 2, dat(2, 0, b));
      for (int b = 4; b < 10; b++) push_exp(-1, 1, b == 7 || b == 9, dat(1, 0, b));
      drain(2, 60, "burst_split");

      // almost_full in IDLE blocks grants until it clears.
      do_reset();
      add_pkt(0, 0, 1);
      add_pkt(2, 0, 1);
      push_exp(11, 0, 1'b1, dat(0, 0, 0));
      push_exp(13, 2, 1'b1, dat(2, 0, 0));
      drain(3, 30, "af_idle");

      // almost_full mid-grant with tready toggling; burst ends at beat 4, regrant waits.
      do_reset();
      add_pkt(3, 0, 5);
      push_exp(1, 3, 1'b0, dat(3, 0, 0));
      push_exp(2, 3, 1'b0, dat(3, 0, 1));
      push_exp(4, 3, 1'b0, dat(3, 0, 2));
      push_exp(6, 3, 1'b1, dat(3, 0, 3));
      push_exp(17, 3, 1'b1, dat(3, 0, 4));
      drain(4, 40, "af_xfer");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axi_fifo_rr_arb.md
Name: axi_fifo_rr_arb

Overview:
- Round-robin arbiter that shares one axi_fifo_18 write port between NUM_PORTS AXI-Stream requesters.
- Grants one requester at a time. A grant lasts until that requester's packet ends (tlast) or until BURST_LEN beats have been accepted.
- The output is tagged with the source ID so downstream logic can demultiplex.
- Uses the FIFO's almost_full flag to stop issuing new grants before the FIFO fills.

Parameters:
- DATA_WIDTH, 32, payload width per port.
- NUM_PORTS, 4, number of requesters; legal range 2..2**ID_WIDTH.
- ID_WIDTH, 2, width of the grant / tid field.
- BURST_LEN, 16, maximum beats per grant; legal range 1..255.

Ports:
- clk  in  1  clock.
- sync_reset  in  1  synchronous reset, active-high.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tlast  in  NUM_PORTS  per-port end of packet.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- fifo_almost_full  in  1  almost_full from the downstream FIFO.
- m_axis_tvalid  out  1  to FIFO s_axis_tvalid.
- m_axis_tdata  out  DATA_WIDTH  to FIFO s_axis_tdata.
- m_axis_tlast  out  1  end of packet or end of burst.
- m_axis_tid  out  ID_WIDTH  source port of the current beat.
- m_axis_tready  in  1  from FIFO s_axis_tready.
- busy  out  1  high while in XFER.

Behaviour:
- States: IDLE, XFER.
- Reset values:
  - state = IDLE.
  - last_grant = NUM_PORTS-1, so port 0 has first priority.
  - grant = 0.
  - beat_cnt = 0.
  - Outputs: m_axis_tvalid = 0, s_axis_tready = 0, busy = 0, m_axis_tid = 0, m_axis_tlast = 0.
- IDLE behaviour:
  - Outputs: m_axis_tvalid = 0, all s_axis_tready = 0.
  - When fifo_almost_full = 0 and any s_axis_tvalid = 1:
    - Search ports last_grant+1, last_grant+2, ... modulo NUM_PORTS.
    - Register the first valid port as grant, set beat_cnt = 0, go to XFER next cycle.
  - When fifo_almost_full = 1, no grant is issued, whatever the requests.
- XFER datapath (combinational from grant):
  - m_axis_tvalid = s_axis_tvalid[grant].
  - m_axis_tdata = s_axis_tdata[grant].
  - m_axis_tid = grant.
  - s_axis_tready[grant] = m_axis_tready; all other s_axis_tready = 0.
  - No added latency through the block.
- Beat accepted = m_axis_tvalid & m_axis_tready. On each accepted beat, beat_cnt increments.
- m_axis_tlast = s_axis_tlast[grant] | (beat_cnt == BURST_LEN-1).
  - A burst truncation therefore marks tlast even though the source packet continues.
- Grant end:
  - On an accepted beat with m_axis_tlast = 1: last_grant <= grant, state <= IDLE.
  - The next grant is evaluated in that IDLE cycle, giving exactly one bubble cycle between grants.
- fifo_almost_full during XFER:
  - Does not stop the current grant; the grant continues, throttled only by m_axis_tready.
  - almost_full is only an admission control.
- Source drops tvalid mid-grant: the grant is held and the block waits. There is no timeout.
- Round-robin fairness: a port that just finished has lowest priority at the next arbitration.
- Single active requester: that port is re-granted after each one-cycle bubble.
- Reset mid-XFER: returns to IDLE next cycle.
  - Outputs go to their reset values.
  - The partial packet is abandoned; the downstream FIFO handles its own reset.
- Width rules:
  - beat_cnt is 8 bits.
  - The round-robin index wraps modulo NUM_PORTS (not 2**ID_WIDTH).
  - Unused tid codes are never driven.

Test Plan:
- Ports 0..3 each hold 3-beat packets, m_axis_tready = 1, fifo_almost_full = 0 -> tid sequence 0,0,0,1,1,1,2,2,2,3,3,3. tlast on every 3rd beat. One idle cycle between packets. First grant valid 1 cycle after request.
- BURST_LEN = 4; port 1 sends a 10-beat packet, port 2 requesting -> port 1 sends 4 beats (tlast on beat 4), then port 2's packet, then port 1 resumes with its remaining 6 beats split 4+2.
- fifo_almost_full = 1 in IDLE with ports 0 and 2 valid -> m_axis_tvalid stays 0 indefinitely. Deassert -> port 0 granted the next cycle.
- almost_full asserted on beat 2 of a 5-beat packet on port 3, with m_axis_tready toggling 1,0,1,0 -> all 5 beats delivered in order with matching data. No new grant afterwards until almost_full clears.
- sync_reset on beat 2 of a 4-beat packet -> next cycle m_axis_tvalid = 0 and s_axis_tready = 0. After reset, port 0 has priority even though port 2 was active.
- Only port 3 active with continuous 1-beat packets -> grant every 2 cycles, tid = 3, s_axis_tready[0..2] = 0 always.
